// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_gen
//  Purpose  : VGA timing generator. Counts pixels/lines on vga_clk, drives
//             hs/vs to the monitor and DrawX/DrawY/blank to the renderers,
//             plus frame_start/vblank_start strobes and an 8-bit frame count.
//  Ports    : vga_clk      - pixel clock, sole clock
//             reset        - synchronous, active-high
//             DrawX/DrawY  - current pixel column / line
//             hs/vs        - syncs, asserted level HS_POL/VS_POL
//             blank        - 1 = visible pixel (display enable)
//             frame_start  - 1-cycle pulse at (0,0)
//             vblank_start - 1-cycle pulse at (0,V_ACTIVE)
//             frame_count  - increments with vblank_start, wraps 255->0
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0
) (
   input  logic       vga_clk,
   input  logic       reset,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       frame_start,
   output logic       vblank_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] c_H_MAX      = 10'(H_TOTAL - 1);
   localparam logic [9:0] c_V_MAX      = 10'(V_TOTAL - 1);
   localparam logic [9:0] c_H_ACTIVE   = 10'(H_ACTIVE);
   localparam logic [9:0] c_V_ACTIVE   = 10'(V_ACTIVE);
   localparam logic [9:0] c_HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] c_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] c_VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] c_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       blank_q, blank_d;
   logic       fs_q, fs_d;
   logic       vbs_q, vbs_d;
   logic [7:0] fc_q, fc_d;

   // Every output is computed from the *next* counter values so that after
   // the edge all outputs describe the same pixel as DrawX/DrawY, with no
   // combinational logic between the counters and the pins.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      // ">=" rather than "==" makes any out-of-range value wrap immediately.
      if (x_q >= c_H_MAX) begin
         x_d = '0;
         if (y_q >= c_V_MAX) y_d = '0;
         else                y_d = y_q + 10'd1;
      end else begin
         x_d = x_q + 10'd1;
      end

      hs_d    = ((x_d >= c_HS_START) && (x_d <= c_HS_END)) ? HS_POL : ~HS_POL;
      vs_d    = ((y_d >= c_VS_START) && (y_d <= c_VS_END)) ? VS_POL : ~VS_POL;
      blank_d = (x_d < c_H_ACTIVE) && (y_d < c_V_ACTIVE);
      fs_d    = (x_d == 10'd0) && (y_d == 10'd0);
      vbs_d   = (x_d == 10'd0) && (y_d == c_V_ACTIVE);
      // Count advances on the same edge that raises vblank_start, so the
      // visible region of a frame always sees a stable value.
      fc_d    = vbs_d ? (fc_q + 8'd1) : fc_q;
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         // Park on the last pixel of the frame so release lands on (0,0).
         x_q     <= c_H_MAX;
         y_q     <= c_V_MAX;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         blank_q <= 1'b0;
         fs_q    <= 1'b0;
         vbs_q   <= 1'b0;
         fc_q    <= '0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         blank_q <= blank_d;
         fs_q    <= fs_d;
         vbs_q   <= vbs_d;
         fc_q    <= fc_d;
      end
   end

   assign DrawX        = x_q;
   assign DrawY        = y_q;
   assign hs           = hs_q;
   assign vs           = vs_q;
   assign blank        = blank_q;
   assign frame_start  = fs_q;
   assign vblank_start = vbs_q;
   assign frame_count  = fc_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sync_gen
//  Purpose  : Directed self-checking bench. A default-timing instance covers
//             reset, release and one full line; a small-timing instance
//             (16x8 frame, HS_POL=1) covers frame-level sync, strobes,
//             frame counter wrap and mid-frame reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic       rst0, rst1;
   logic [9:0] x0, y0, x1, y1;
   logic       hs0, vs0, bl0, fs0, vb0;
   logic       hs1, vs1, bl1, fs1, vb1;
   logic [7:0] fc0, fc1;

   int total = 0;
   int fails = 0;

   vga_sync_gen u_dut0 (
      .vga_clk(clk), .reset(rst0), .DrawX(x0), .DrawY(y0), .hs(hs0), .vs(vs0),
      .blank(bl0), .frame_start(fs0), .vblank_start(vb0), .frame_count(fc0)
   );

   vga_sync_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .HS_POL(1'b1), .VS_POL(1'b0)
   ) u_dut1 (
      .vga_clk(clk), .reset(rst1), .DrawX(x1), .DrawY(y1), .hs(hs1), .vs(vs1),
      .blank(bl1), .frame_start(fs1), .vblank_start(vb1), .frame_count(fc1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int hs_low, hs_min, hs_max, bl_cnt, bl_max, xerr, vserr;
      int vs_low, hs_hi, fs_n, fs_pos, vb_n, vb_pos, vb_fc, fc_vis_err;
      int prev, step_err, saw255, n;

      // ---------------- reset, both instances ----------------
      rst0 = 1'b1;
      rst1 = 1'b1;
      repeat (3) step;
      chk("rst0_x",  32'(x0), 32'd799);
      chk("rst0_y",  32'(y0), 32'd524);
      chk("rst0_bl", 32'(bl0), 32'd0);
      chk("rst0_hs", 32'(hs0), 32'd1);
      chk("rst0_vs", 32'(vs0), 32'd1);
      chk("rst0_fs", 32'(fs0), 32'd0);
      chk("rst0_vb", 32'(vb0), 32'd0);
      chk("rst0_fc", 32'(fc0), 32'd0);
      chk("rst1_x",  32'(x1), 32'd15);
      chk("rst1_y",  32'(y1), 32'd7);
      chk("rst1_hs", 32'(hs1), 32'd0);
      chk("rst1_vs", 32'(vs1), 32'd1);
      chk("rst1_bl", 32'(bl1), 32'd0);

      // ---------------- release default instance ----------------
      rst0 = 1'b0;
      step;
      chk("rel0_x",  32'(x0), 32'd0);
      chk("rel0_y",  32'(y0), 32'd0);
      chk("rel0_bl", 32'(bl0), 32'd1);
      chk("rel0_fs", 32'(fs0), 32'd1);
      chk("rel0_hs", 32'(hs0), 32'd1);
      chk("rel0_fc", 32'(fc0), 32'd0);

      // ---------------- one full default line ----------------
      hs_low = 0; hs_min = 1023; hs_max = 0; bl_cnt = 0; bl_max = -1;
      xerr = 0; vserr = 0;
      for (int i = 0; i < 800; i++) begin
         if (x0 !== 10'(i) || y0 !== 10'd0) xerr++;
         if (vs0 !== 1'b1) vserr++;
         if (hs0 === 1'b0) begin
            hs_low++;
            if (int'(x0) < hs_min) hs_min = int'(x0);
            if (int'(x0) > hs_max) hs_max = int'(x0);
         end
         if (bl0 === 1'b1) begin
            bl_cnt++;
            bl_max = int'(x0);
         end
         step;
      end
      chk("line_xseq",   32'(xerr), 32'd0);
      chk("line_vs",     32'(vserr), 32'd0);
      chk("line_hs_cnt", 32'(hs_low), 32'd96);
      chk("line_hs_min", 32'(hs_min), 32'd656);
      chk("line_hs_max", 32'(hs_max), 32'd751);
      chk("line_bl_cnt", 32'(bl_cnt), 32'd640);
      chk("line_bl_max", 32'(bl_max), 32'd639);
      chk("line_wrap_x", 32'(x0), 32'd0);
      chk("line_wrap_y", 32'(y0), 32'd1);
      chk("line_wrap_fs", 32'(fs0), 32'd0);

      // ---------------- release small instance ----------------
      rst1 = 1'b0;
      step;
      chk("rel1_x",  32'(x1), 32'd0);
      chk("rel1_y",  32'(y1), 32'd0);
      chk("rel1_fs", 32'(fs1), 32'd1);
      chk("rel1_bl", 32'(bl1), 32'd1);
      chk("rel1_hs", 32'(hs1), 32'd0);

      // ---------------- one full small frame (128 cycles) ----------------
      vs_low = 0; hs_hi = 0; bl_cnt = 0; fs_n = 0; fs_pos = -1;
      vb_n = 0; vb_pos = -1; vb_fc = -1; fc_vis_err = 0;
      hs_min = 1023; hs_max = 0;
      for (int i = 0; i < 128; i++) begin
         if (vs1 === 1'b0) vs_low++;
         if (bl1 === 1'b1) begin
            bl_cnt++;
            if (fc1 !== 8'd0) fc_vis_err++;
         end
         if (hs1 === 1'b1) begin
            hs_hi++;
            if (int'(x1) < hs_min) hs_min = int'(x1);
            if (int'(x1) > hs_max) hs_max = int'(x1);
         end
         if (fs1 === 1'b1) begin fs_n++; fs_pos = int'(y1) * 16 + int'(x1); end
         if (vb1 === 1'b1) begin vb_n++; vb_pos = int'(y1) * 16 + int'(x1); vb_fc = int'(fc1); end
         step;
      end
      chk("frm_vs_low", 32'(vs_low), 32'd16);
      chk("frm_bl_cnt", 32'(bl_cnt), 32'd32);
      chk("frm_hs_hi",  32'(hs_hi), 32'd24);
      chk("frm_hs_min", 32'(hs_min), 32'd10);
      chk("frm_hs_max", 32'(hs_max), 32'd12);
      chk("frm_fs_n",   32'(fs_n), 32'd1);
      chk("frm_fs_pos", 32'(fs_pos), 32'd0);
      chk("frm_vb_n",   32'(vb_n), 32'd1);
      chk("frm_vb_pos", 32'(vb_pos), 32'd64);
      chk("frm_vb_fc",  32'(vb_fc), 32'd1);
      chk("frm_fc_vis", 32'(fc_vis_err), 32'd0);
      chk("frm_per_x",  32'(x1), 32'd0);
      chk("frm_per_y",  32'(y1), 32'd0);
      chk("frm_per_fs", 32'(fs1), 32'd1);
      chk("frm_per_fc", 32'(fc1), 32'd1);

      // ---------------- frame counter through wrap ----------------
      prev = 1; step_err = 0; saw255 = 0;
      for (int f = 1; f < 256; f++) begin
         for (int c = 0; c < 128; c++) begin
            if (vb1 === 1'b1) begin
               if (fc1 !== 8'((prev + 1) % 256)) step_err++;
               prev = int'(fc1);
               if (fc1 === 8'd255) saw255 = 1;
            end
            step;
         end
      end
      chk("fc_steps",  32'(step_err), 32'd0);
      chk("fc_saw255", 32'(saw255), 32'd1);
      chk("fc_wrap",   32'(fc1), 32'd0);
      chk("fc_wrap_x", 32'(x1), 32'd0);
      chk("fc_wrap_y", 32'(y1), 32'd0);

      // ---------------- mid-frame reset at (3,2) of frame 5 ----------------
      n = 0;
      while (!(fc1 === 8'd5 && x1 === 10'd3 && y1 === 10'd2) && n < 2000) begin
         step;
         n++;
      end
      chk("wait_f5", 32'(n < 2000), 32'd1);
      rst1 = 1'b1;
      step;
      chk("mrst_x",  32'(x1), 32'd15);
      chk("mrst_y",  32'(y1), 32'd7);
      chk("mrst_fc", 32'(fc1), 32'd0);
      chk("mrst_fs", 32'(fs1), 32'd0);
      chk("mrst_vb", 32'(vb1), 32'd0);
      chk("mrst_bl", 32'(bl1), 32'd0);
      rst1 = 1'b0;
      step;
      chk("mrel_x",  32'(x1), 32'd0);
      chk("mrel_y",  32'(y1), 32'd0);
      chk("mrel_fs", 32'(fs1), 32'd1);
      chk("mrel_fc", 32'(fc1), 32'd0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
`default_nettype wire
